regfile_wb_sb: RTL and testbench



---
 rtl/regfile_pkg.sv | 9 +
 rtl/regfile_scoreboard.sv | 89 ++++++++
 rtl/regfile_wb_sb.sv | 72 +++++++
 tb/tb_regfile_wb_sb.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared constants for the writeback-side register file and its pending-write scoreboard.
package regfile_pkg;

    localparam int unsigned REG_ADDR_W    = 5;
    localparam int unsigned NUM_REGS      = 32;
    localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;
    localparam int unsigned CNT_W_DEFAULT = 2;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register pending-write counters, RAW/overflow stall and busy flag.
// REGFILE_WB_BYPASS_EN lets a source retiring this cycle (cnt==1) skip the stall.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  reg_write_i,
    input  logic [REG_ADDR_W-1:0] regdst_i,
    input  logic [REG_ADDR_W-1:0] rs_addr_i,
    input  logic [REG_ADDR_W-1:0] rt_addr_i,
    input  logic                  rs_used_i,
    input  logic                  rt_used_i,
    input  logic                  issue_valid_i,
    input  logic                  issue_wr_i,
    input  logic [REG_ADDR_W-1:0] issue_dst_i,
    output logic                  stall_o,
    output logic                  busy_any_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0]    cnt_q [NUM_REGS];
    logic [CNT_W-1:0]    cnt_d [NUM_REGS];
    logic                busy_any_q;
    logic                busy_any_d;
    logic [NUM_REGS-1:0] inc_vec;
    logic [NUM_REGS-1:0] dec_vec;
    logic                retire_c;
    logic                rs_retire_c;
    logic                rt_retire_c;
    logic                rs_pend_c;
    logic                rt_pend_c;
    logic                full_c;
    logic                inc_c;

    assign retire_c = reg_write_i && (regdst_i != ZERO_REG);

`ifdef REGFILE_WB_BYPASS_EN
    assign rs_retire_c = retire_c && (regdst_i == rs_addr_i) && (cnt_q[rs_addr_i] == CNT_W'(1));
    assign rt_retire_c = retire_c && (regdst_i == rt_addr_i) && (cnt_q[rt_addr_i] == CNT_W'(1));
`else
    assign rs_retire_c = 1'b0;
    assign rt_retire_c = 1'b0;
`endif

    assign rs_pend_c = rs_used_i && (rs_addr_i != ZERO_REG) && (cnt_q[rs_addr_i] != '0) && !rs_retire_c;
    assign rt_pend_c = rt_used_i && (rt_addr_i != ZERO_REG) && (cnt_q[rt_addr_i] != '0) && !rt_retire_c;
    assign full_c    = issue_wr_i && (issue_dst_i != ZERO_REG) && (cnt_q[issue_dst_i] == CNT_MAX);

    assign stall_o = !rst && issue_valid_i && (rs_pend_c || rt_pend_c || full_c);
    assign inc_c   = issue_valid_i && issue_wr_i && (issue_dst_i != ZERO_REG) && !stall_o;

    // Decrement saturates at zero so stray writebacks after reset are harmless.
    always_comb begin
        inc_vec = '0;
        dec_vec = '0;
        if (inc_c) inc_vec[issue_dst_i] = 1'b1;
        if (retire_c && (cnt_q[regdst_i] != '0)) dec_vec[regdst_i] = 1'b1;
    end

    always_comb begin
        busy_any_d = 1'b0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            cnt_d[i] = cnt_q[i];
            if (inc_vec[i] && !dec_vec[i]) begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end else if (dec_vec[i] && !inc_vec[i]) begin
                cnt_d[i] = cnt_q[i] - CNT_W'(1);
            end
            busy_any_d = busy_any_d | (cnt_q[i] != '0);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) cnt_q[i] <= '0;
            busy_any_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            busy_any_q <= busy_any_d;
        end
    end

    assign busy_any_o = busy_any_q;

endmodule

// File: rtl/regfile_wb_sb.sv
// 32x32 register file fed by writeback, two combinational decode read ports, plus scoreboard.
// REGFILE_WB_BYPASS_EN adds write-through from the writeback port to both read ports.
module regfile_wb_sb
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = CNT_W_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  reg_write,
    input  logic [DATA_W-1:0]     data_to_reg,
    input  logic [REG_ADDR_W-1:0] regdst,
    input  logic [REG_ADDR_W-1:0] rs_addr,
    input  logic [REG_ADDR_W-1:0] rt_addr,
    input  logic                  rs_used,
    input  logic                  rt_used,
    output logic [DATA_W-1:0]     rs_data,
    output logic [DATA_W-1:0]     rt_data,
    input  logic                  issue_valid,
    input  logic                  issue_wr,
    input  logic [REG_ADDR_W-1:0] issue_dst,
    output logic                  stall,
    output logic                  busy_any
);

    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic              wr_en_c;

    assign wr_en_c = reg_write && (regdst != ZERO_REG);

    // r0 is never written, so it stays at its reset value of zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
        end else if (wr_en_c) begin
            regs_q[regdst] <= data_to_reg;
        end
    end

    always_comb begin
        rs_data = regs_q[rs_addr];
        rt_data = regs_q[rt_addr];
`ifdef REGFILE_WB_BYPASS_EN
        if (wr_en_c && (regdst == rs_addr)) rs_data = data_to_reg;
        if (wr_en_c && (regdst == rt_addr)) rt_data = data_to_reg;
`endif
        if (rst) begin
            rs_data = '0;
            rt_data = '0;
        end
    end

    regfile_scoreboard #(
        .CNT_W (CNT_W)
    ) u_sb (
        .clk           (clk),
        .rst           (rst),
        .reg_write_i   (reg_write),
        .regdst_i      (regdst),
        .rs_addr_i     (rs_addr),
        .rt_addr_i     (rt_addr),
        .rs_used_i     (rs_used),
        .rt_used_i     (rt_used),
        .issue_valid_i (issue_valid),
        .issue_wr_i    (issue_wr),
        .issue_dst_i   (issue_dst),
        .stall_o       (stall),
        .busy_any_o    (busy_any)
    );

endmodule

// File: tb/tb_regfile_wb_sb.sv
// Scoreboard bench: driver pushes per-cycle expectations from a register/counter model; monitor compares.
module tb_regfile_wb_sb;

    localparam int CMAX = 3;
`ifdef REGFILE_WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        reg_write = 1'b0;
    logic [31:0] data_to_reg = '0;
    logic [4:0]  regdst = '0;
    logic [4:0]  rs_addr = '0;
    logic [4:0]  rt_addr = '0;
    logic        rs_used = 1'b0;
    logic        rt_used = 1'b0;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        issue_valid = 1'b0;
    logic        issue_wr = 1'b0;
    logic [4:0]  issue_dst = '0;
    logic        stall;
    logic        busy_any;

    regfile_wb_sb #(.DATA_W(32), .CNT_W(2)) dut (
        .clk(clk), .rst(rst), .reg_write(reg_write), .data_to_reg(data_to_reg),
        .regdst(regdst), .rs_addr(rs_addr), .rt_addr(rt_addr), .rs_used(rs_used),
        .rt_used(rt_used), .rs_data(rs_data), .rt_data(rt_data),
        .issue_valid(issue_valid), .issue_wr(issue_wr), .issue_dst(issue_dst),
        .stall(stall), .busy_any(busy_any)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        stall;
        logic        busy;
        logic [31:0] rs;
        logic [31:0] rt;
    } exp_t;

    exp_t        q[$];
    exp_t        mon_e;
    int          checks = 0;
    int          failures = 0;
    logic [31:0] m_regs [32];
    int          m_cnt  [32];
    bit          m_busy = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0t got=%h exp=%h", name, $time, act, exp);
        end
    endtask

    // Monitor: one expectation per cycle, sampled mid-cycle.
    initial forever begin
        @(negedge clk);
        if (q.size() > 0) begin
            mon_e = q.pop_front();
            chk("stall", 32'(stall), 32'(mon_e.stall));
            chk("busy_any", 32'(busy_any), 32'(mon_e.busy));
            chk("rs_data", rs_data, mon_e.rs);
            chk("rt_data", rt_data, mon_e.rt);
        end
    end

    function automatic bit pend(input logic [4:0] a, input logic u);
        if (!u || a == 0 || m_cnt[a] == 0) return 1'b0;
        if (BYP && m_cnt[a] == 1 && reg_write && regdst == a) return 1'b0;
        return 1'b1;
    endfunction

    function automatic bit model_stall();
        if (rst || !issue_valid) return 1'b0;
        return pend(rs_addr, rs_used) || pend(rt_addr, rt_used) ||
               (issue_wr && issue_dst != 0 && m_cnt[issue_dst] == CMAX);
    endfunction

    function automatic logic [31:0] model_read(input logic [4:0] a);
        if (rst || a == 0) return 32'h0;
        if (BYP && reg_write && regdst == a) return data_to_reg;
        return m_regs[a];
    endfunction

    task automatic model_update(input bit st);
        bit any;
        if (rst) begin
            for (int i = 0; i < 32; i++) begin m_regs[i] = '0; m_cnt[i] = 0; end
            m_busy = 1'b0;
        end else begin
            any = 1'b0;
            for (int i = 0; i < 32; i++) if (m_cnt[i] != 0) any = 1'b1;
            if (reg_write && regdst != 0) begin
                m_regs[regdst] = data_to_reg;
                if (m_cnt[regdst] > 0) m_cnt[regdst]--;
            end
            if (issue_valid && issue_wr && issue_dst != 0 && !st) m_cnt[issue_dst]++;
            m_busy = any;
        end
    endtask

    task automatic drive(input logic r, input logic rw, input logic [31:0] d, input logic [4:0] rd,
                         input logic [4:0] ra, input logic ru, input logic [4:0] rb, input logic tu,
                         input logic iv, input logic iw, input logic [4:0] id);
        exp_t e;
        bit   st;
        rst = r; reg_write = rw; data_to_reg = d; regdst = rd;
        rs_addr = ra; rs_used = ru; rt_addr = rb; rt_used = tu;
        issue_valid = iv; issue_wr = iw; issue_dst = id;
        st      = model_stall();
        e.stall = st;
        e.busy  = rst ? 1'b0 : m_busy;
        e.rs    = model_read(ra);
        e.rt    = model_read(rb);
        q.push_back(e);
        @(posedge clk);
        model_update(st);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) begin m_regs[i] = '0; m_cnt[i] = 0; end
        @(posedge clk);
        #1;
        // reset state
        drive(1, 0, 0, 0, 5, 1, 9, 1, 1, 1, 5);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        // r5 = 0x1234 with one pending write, then async reset mid-cycle
        drive(0, 1, 32'h1234, 5, 0, 0, 0, 0, 1, 1, 5);
        drive(0, 0, 0, 0, 5, 1, 0, 0, 1, 0, 0);
        drive(1, 0, 0, 0, 5, 1, 5, 1, 1, 1, 5);
        drive(0, 0, 0, 0, 5, 1, 5, 0, 1, 0, 0);
        // basic write/read and r0 hardwiring
        drive(0, 1, 32'hDEADBEEF, 3, 3, 0, 0, 0, 0, 0, 0);
        drive(0, 1, 32'hFFFFFFFF, 0, 3, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 1, 3, 1, 1, 0, 0);
        // RAW on r7
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 7);
        drive(0, 0, 0, 0, 7, 1, 0, 0, 1, 0, 0);
        drive(0, 0, 0, 0, 7, 1, 0, 0, 1, 0, 0);
        drive(0, 1, 32'hA5A50007, 7, 7, 1, 7, 0, 1, 0, 0);
        drive(0, 0, 0, 0, 7, 1, 0, 0, 1, 0, 0);
        // simultaneous inc/dec on r9 at cnt=1
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 9);
        drive(0, 1, 32'h99, 9, 0, 0, 0, 0, 1, 1, 9);
        drive(0, 0, 0, 0, 9, 1, 9, 1, 1, 0, 0);
        drive(0, 1, 32'h199, 9, 0, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 9, 1, 9, 1, 1, 0, 0);
        // overflow guard on r4
        for (int k = 0; k < 3; k++) drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 4);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 4);
        drive(0, 1, 32'h44, 4, 0, 0, 0, 0, 1, 1, 4);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 4);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 4);
        for (int k = 0; k < 4; k++) drive(0, 1, 32'(k), 4, 4, 1, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        // spurious writeback to r12
        drive(0, 1, 32'hC0FFEE12, 12, 12, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 12, 1, 12, 1, 1, 0, 0);
        drive(0, 0, 0, 0, 12, 0, 0, 0, 0, 0, 0);
        // randomized traffic over a small register window to provoke hazards
        for (int k = 0; k < 600; k++) begin
            drive(($urandom_range(0, 79) == 0),
                  ($urandom_range(0, 1) == 1), $urandom(), 5'($urandom_range(0, 7)),
                  5'($urandom_range(0, 7)), ($urandom_range(0, 3) != 0),
                  5'($urandom_range(0, 7)), ($urandom_range(0, 1) == 1),
                  ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) != 0),
                  5'($urandom_range(0, 7)));
        end
        rst = 1'b0; reg_write = 1'b0; issue_valid = 1'b0;
        for (int k = 0; k < 10 && q.size() > 0; k++) @(negedge clk);
        #1;
        if (q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain pending=%0d required=0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
